// File: rtl/alu_pkg.sv
// Shared ALUControl codes and execute-unit FSM state type.
// Imported by the control decoder and the ALU execute stage.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] code);
    return (code == ALU_SLL) || (code == ALU_SRL) || (code == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_comb_ops.sv
// Single-cycle ALU operations (logic, add/sub, compares).
// Unlisted codes, including 1010-1111, execute as ADD.
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] res
);

  always_comb begin
    res = op_a + op_b;
    case (alu_ctrl)
      ALU_AND:  res = op_a & op_b;
      ALU_OR:   res = op_a | op_b;
      ALU_XOR:  res = op_a ^ op_b;
      ALU_SUB:  res = op_a - op_b;
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      default:  res = op_a + op_b;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle logic/arith ops, serial one-bit-per-cycle
// shifter, valid/ready handshake on issue and result sides.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SHW = $clog2(XLEN);

  alu_state_e      state, state_n;
  logic [SHW-1:0]  cnt, cnt_n;
  logic [3:0]      sh_ctrl, sh_ctrl_n;
  logic [XLEN-1:0] result_n;
  logic [XLEN-1:0] comb_res;
  logic [XLEN-1:0] shifted;

  alu_comb_ops #(.XLEN(XLEN)) u_comb (
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .res      (comb_res)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign zero      = (result == '0);

  always_comb begin
    case (sh_ctrl)
      ALU_SLL: shifted = {result[XLEN-2:0], 1'b0};
      ALU_SRL: shifted = {1'b0, result[XLEN-1:1]};
      default: shifted = {result[XLEN-1], result[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    sh_ctrl_n = sh_ctrl;
    result_n  = result;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_shift(alu_ctrl)) begin
            // result register doubles as the shift register
            result_n  = op_a;
            cnt_n     = op_b[SHW-1:0];
            sh_ctrl_n = alu_ctrl;
            state_n   = (op_b[SHW-1:0] == '0) ? ST_DONE : ST_SHIFT;
          end else begin
            result_n = comb_res;
            state_n  = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        result_n = shifted;
        cnt_n    = cnt - SHW'(1);
        if (cnt == SHW'(1)) state_n = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sh_ctrl <= '0;
      result  <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sh_ctrl <= sh_ctrl_n;
      result  <= result_n;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, reset and
// backpressure sequences, and a randomized stream against a reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned k;
    k = b[4:0];
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1000: return (a < b) ? 32'd1 : 32'd0;
      4'b0100: return a << k;
      4'b0101: return a >> k;
      4'b1001: return 32'($signed(a) >>> k);
      default: return a + b;
    endcase
  endfunction

  // Issue one op from IDLE; returns result, zero and cycles from accept to out_valid.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output bit timeout);
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom); op_a = $urandom; op_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; z = zero; timeout = !out_valid;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] r;
  logic        z;
  int          lat;
  bit          to;

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_ctrl = '0; op_a = '0; op_b = '0; out_ready = 1'b1;

    vecs.push_back('{4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         1});
    vecs.push_back('{4'b0110, 32'h5,         32'h5,         32'h0,         1});
    vecs.push_back('{4'b1111, 32'h2,         32'h3,         32'h5,         1});
    vecs.push_back('{4'b1010, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1});
    vecs.push_back('{4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h1,         1});
    vecs.push_back('{4'b1000, 32'hFFFF_FFFF, 32'h1,         32'h0,         1});
    vecs.push_back('{4'b0111, 32'h1,         32'hFFFF_FFFF, 32'h0,         1});
    vecs.push_back('{4'b1000, 32'h1,         32'hFFFF_FFFF, 32'h1,         1});
    vecs.push_back('{4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0,         1});
    vecs.push_back('{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1});
    vecs.push_back('{4'b0001, 32'h0000_FF00, 32'h00FF_0000, 32'h00FF_FF00, 1});
    vecs.push_back('{4'b1001, 32'h8000_0000, 32'h24,        32'hF800_0000, 5});
    vecs.push_back('{4'b0101, 32'h8000_0000, 32'h24,        32'h0800_0000, 5});
    vecs.push_back('{4'b0100, 32'h1,         32'd31,        32'h8000_0000, 32});
    vecs.push_back('{4'b0100, 32'h1234_5678, 32'h20,        32'h1234_5678, 1});
    vecs.push_back('{4'b1001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32});

    // Reset and idle state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready",  32'(in_ready),  32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result",    result,         32'd0);
    chk("reset_zero",      32'(zero),      32'd1);
    @(negedge clk); rst = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      run_op(vecs[i].c, vecs[i].a, vecs[i].b, r, z, lat, to);
      chk($sformatf("vec%0d_timeout", i), 32'(to), 32'd0);
      chk($sformatf("vec%0d_result", i), r, vecs[i].exp);
      chk($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].exp == 32'd0));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Reset during SHIFT of SLL by 20: op dropped, no out_valid pulse
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b0100; op_a = 32'h1; op_b = 32'd20;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("shift_no_early_valid", 32'(out_valid), 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_shift_in_ready",  32'(in_ready),  32'd1);
    chk("rst_shift_out_valid", 32'(out_valid), 32'd0);
    chk("rst_shift_result",    result,         32'd0);
    chk("rst_shift_zero",      32'(zero),      32'd1);
    @(negedge clk); rst = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      chk("rst_shift_no_valid", 32'(out_valid), 32'd0);
    end

    // Backpressure: hold out_ready low, ignored issue attempts
    out_ready = 1'b0;
    run_op(4'b0010, 32'd7, 32'd8, r, z, lat, to);
    chk("bp_timeout", 32'(to), 32'd0);
    chk("bp_result", r, 32'd15);
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = 1'b1; alu_ctrl = 4'b0110; op_a = 32'd9; op_b = 32'd9;
      @(posedge clk); #1;
      chk("bp_hold_valid",  32'(out_valid), 32'd1);
      chk("bp_in_ready",    32'(in_ready),  32'd0);
      chk("bp_hold_result", result,         32'd15);
      chk("bp_hold_zero",   32'(zero),      32'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid",  32'(out_valid), 32'd0);
    chk("bp_release_ready",  32'(in_ready),  32'd1);
    chk("bp_release_result", result,         32'd15);
    run_op(4'b0000, 32'hFF00_FF00, 32'h0FF0_0FF0, r, z, lat, to);
    chk("bp_next_result",  r, 32'h0F00_0F00);
    chk("bp_next_latency", 32'(lat), 32'd1);

    // Reset while DONE: result dropped
    out_ready = 1'b0;
    run_op(4'b0010, 32'd1, 32'd1, r, z, lat, to);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_done_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done_result",    result,         32'd0);
    @(negedge clk); rst = 1'b0; out_ready = 1'b1;

    // Random stream with random in_valid/out_ready against reference model
    begin
      logic [31:0] q[$];
      int          accepted = 0;
      int          got      = 0;
      int          cyc      = 0;
      logic        prev_hold = 1'b0;
      logic [31:0] prev_res  = '0;
      while ((accepted < 1000 || q.size() > 0) && cyc < 80000) begin
        @(negedge clk);
        cyc++;
        if (prev_hold) begin
          chk("rnd_hold_valid",  32'(out_valid), 32'd1);
          chk("rnd_hold_result", result,         prev_res);
        end
        in_valid  = (accepted < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        alu_ctrl  = 4'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        out_ready = 1'($urandom_range(0, 1));
        #1;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("rnd_unexpected_result", 32'd1, 32'd0);
          end else begin
            chk($sformatf("rnd_result%0d", got), result, q.pop_front());
            got++;
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(ref_alu(alu_ctrl, op_a, op_b));
          accepted++;
        end
        prev_hold = out_valid && !out_ready;
        prev_res  = result;
      end
      chk("rnd_timeout", 32'(cyc >= 80000), 32'd0);
      chk("rnd_count",   32'(got),          32'd1000);
    end

    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU consumer of the 4-bit ALUControl code produced by the ALU control decoder.
- Performs the operation on two XLEN-bit operands and returns a registered result plus a zero flag to the branch/writeback logic.
- Logic/arithmetic/compare ops complete in one cycle.
- Shifts use a serial one-bit-per-cycle shifter to save area.
- Valid/ready handshake on both the issue side and the result side.

Parameters:
- XLEN, 32, operand and result width. Power of two, 8 or greater.
- SHW, $clog2(XLEN), shift-amount width, derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  issue request
- in_ready  output  1  unit can accept an op
- alu_ctrl  input  4  ALUControl code
- op_a  input  XLEN  operand A (shift source)
- op_b  input  XLEN  operand B (shift amount = op_b[SHW-1:0])
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- result  output  XLEN  registered result
- zero  output  1  result == 0 (branch-equal test)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset values: state IDLE, in_ready 1, out_valid 0, result 0, zero 1, shift counter 0.
- Code map:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB.
  - 0111 SLT (signed), 1000 SLTU.
  - 0100 SLL, 0101 SRL, 1001 SRA.
  - 1010-1111 execute as ADD.
- Arithmetic: ADD/SUB wrap modulo 2^XLEN, no overflow flag. SLT/SLTU return 1 or 0, zero-extended.
- FSM states: IDLE, SHIFT, DONE.
- in_ready = (state == IDLE). Acceptance occurs on an edge where in_valid and in_ready are both 1. Inputs are sampled only at acceptance and may change afterwards.
- IDLE, accept non-shift op: result computed and registered on that edge; go to DONE.
- IDLE, accept shift with amount k = 0: result = op_a; go to DONE.
- IDLE, accept shift with k > 0: result register loaded with op_a, counter loaded with k; go to SHIFT.
- SHIFT: each edge shifts result one bit and decrements the counter.
  - SLL fills 0 at the LSB.
  - SRL fills 0 at the MSB.
  - SRA replicates the MSB.
  - When the counter is 1, the shift occurs and the state goes to DONE.
- Latency from the accept edge to out_valid visible:
  - 1 cycle for non-shifts and k = 0.
  - k+1 cycles for shifts with k > 0. Maximum is XLEN.
- DONE: out_valid = 1. result and zero are held stable while out_ready = 0.
  - Edge with out_ready = 1: go to IDLE, out_valid drops. result retains its value.
  - No bypass: out_ready in DONE does not enable same-cycle issue. Minimum issue interval is 2 cycles.
- out_valid never deasserts without a handshake, except on reset.
- zero reflects the current result register at all times, so it is combinational from the register.
- in_valid while busy is ignored; no op is queued.
- Reset mid-SHIFT or mid-DONE: op dropped, all reset values restored on that edge. No partial result is delivered.
- Shift amount uses op_b[SHW-1:0] only; upper bits of op_b are ignored.

Decomposition:
- Shared package alu_pkg:
  - ALUControl code localparams (ALU_AND … ALU_SRA), shared with the control decoder.
  - FSM state typedef.
- Sub-module alu_comb_ops: pure combinational single-cycle ops (AND/OR/XOR/ADD/SUB/SLT/SLTU/default ADD).
- The FSM, serial shifter and handshake stay in alu_exec_unit.

Test Plan:
1. Reset, then idle: in_ready=1, out_valid=0, result=0, zero=1. Assert rst during SHIFT of SLL by 20 -> next cycle all reset values, no out_valid pulse.
2. ADD 0xFFFFFFFF + 1, then SUB 5 - 5, with out_ready=1 -> each out_valid 1 cycle after accept; result 0 and zero=1 both times. Code 1111 with 2,3 -> result 5.
3. SLT 0xFFFFFFFF vs 1 -> 1. SLTU same operands -> 0. XOR 0xA5A5A5A5 ^ 0xA5A5A5A5 -> 0 with zero=1 (branch-equal case).
4. SRA 0x80000000 by op_b=0x24 (k=4) -> 0xF8000000, out_valid 5 cycles after accept. SRL same -> 0x08000000. SLL 1 by 31 -> 0x80000000 after 32 cycles. Shift by 0 -> op_a after 1 cycle.
5. Backpressure: hold out_ready=0 for 6 cycles after out_valid -> result/zero stable, in_ready=0. Pulse in_valid with new operands during that time -> ignored. Release -> IDLE next cycle, then the next op is accepted.
6. Random stream of 1000 ops with random in_valid/out_ready -> every accepted op yields exactly one result matching the reference model, in order.
